// File: rtl/rom_scan_ctrl_if.sv
// rtl/rom_scan_ctrl_if.sv - scan request, ROM bus and result signals of rom_scan_ctrl
interface rom_scan_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int SUM_W  = ADDR_W + DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] read_data;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] max_val;
    logic [ADDR_W-1:0] max_addr;

    modport master (
        output start, first_addr, last_addr, read_data,
        input  address, busy, done, sum, max_val, max_addr
    );

    modport slave (
        input  start, first_addr, last_addr, read_data,
        output address, busy, done, sum, max_val, max_addr
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// rtl/rom_scan_ctrl.sv - wrap-around ROM window scanner computing sum and max entry
module rom_scan_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int SUM_W  = ADDR_W + DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    rom_scan_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] last_q, last_n;
    logic [ADDR_W-1:0] max_addr_q, max_addr_n;
    logic [SUM_W-1:0]  sum_q, sum_n;
    logic [DATA_W-1:0] max_q, max_n;
    logic              first_q, first_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            max_addr_q <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            last_q     <= last_n;
            max_addr_q <= max_addr_n;
            sum_q      <= sum_n;
            max_q      <= max_n;
            first_q    <= first_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // busy/done are computed from the next state so they leave the block registered.
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        last_n     = last_q;
        max_addr_n = max_addr_q;
        sum_n      = sum_q;
        max_n      = max_q;
        first_n    = first_q;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_n  = bus.first_addr;
                    last_n  = bus.last_addr;
                    sum_n   = '0;
                    first_n = 1'b1;
                    state_n = SCAN;
                    busy_n  = 1'b1;
                end
            end
            SCAN: begin
                busy_n  = 1'b1;
                sum_n   = sum_q + SUM_W'(bus.read_data);
                first_n = 1'b0;
                // Strict compare keeps the earliest-visited address on ties.
                if (first_q || (bus.read_data > max_q)) begin
                    max_n      = bus.read_data;
                    max_addr_n = addr_q;
                end
                if (addr_q == last_q) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    addr_n = addr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.address  = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.max_val  = max_q;
    assign bus.max_addr = max_addr_q;
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb/tb_rom_scan_ctrl.sv - directed-vector bench for rom_scan_ctrl
module tb_rom_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rom_scan_ctrl_if #(.ADDR_W(3), .DATA_W(4), .SUM_W(7)) bus ();

    rom_scan_ctrl #(.ADDR_W(3), .DATA_W(4), .SUM_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] rom [8];
    initial begin
        rom[0] = 4'd3;  rom[1] = 4'd9; rom[2] = 4'd0; rom[3] = 4'd15;
        rom[4] = 4'd7;  rom[5] = 4'd15; rom[6] = 4'd2; rom[7] = 4'd5;
    end
    assign bus.read_data = rom[bus.address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ign_at > 0: pulse start (first=4) at that SCAN cycle; rst_at > 0: reset at that SCAN cycle.
    task automatic do_scan(input logic [2:0] f, input logic [2:0] l, input int len,
                           input int ign_at, input int rst_at,
                           input logic [6:0] esum, input logic [3:0] emax, input logic [2:0] emaddr);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = 0;
        logic [2:0] exp_addr;
        @(posedge clk); #1;
        bus.first_addr = f; bus.last_addr = l; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= len + 6; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                exp_addr = f + busy_cnt[2:0];
                check("scan_addr", 32'(bus.address), 32'(exp_addr));
                busy_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
                check("done_sum", 32'(bus.sum), 32'(esum));
                check("done_max", 32'(bus.max_val), 32'(emax));
                check("done_maddr", 32'(bus.max_addr), 32'(emaddr));
            end
            if (rst_at > 0 && c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_addr", 32'(bus.address), 32'd0);
                check("rst_sum", 32'(bus.sum), 32'd0);
                check("rst_max", 32'(bus.max_val), 32'd0);
                check("rst_maddr", 32'(bus.max_addr), 32'd0);
                for (int k = 0; k < 10; k++) begin
                    if (bus.done) done_cnt++;
                    @(negedge clk);
                end
                check("rst_no_done", 32'(done_cnt), 32'd0);
                return;
            end
            if (ign_at > 0 && c == ign_at) begin
                bus.start = 1'b1; bus.first_addr = 3'd4;
                @(posedge clk); #1;
                bus.start = 1'b0; bus.first_addr = f;
            end
        end
        check("busy_len", 32'(busy_cnt), 32'(len));
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_cyc), 32'(len + 1));
        check("hold_sum", 32'(bus.sum), 32'(esum));
        check("hold_max", 32'(bus.max_val), 32'(emax));
        check("hold_maddr", 32'(bus.max_addr), 32'(emaddr));
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.first_addr = '0; bus.last_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_addr", 32'(bus.address), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_max", 32'(bus.max_val), 32'd0);
        check("reset_maddr", 32'(bus.max_addr), 32'd0);

        do_scan(3'd0, 3'd7, 8, 0, 0, 7'd56, 4'd15, 3'd3);
        do_scan(3'd5, 3'd1, 5, 0, 0, 7'd34, 4'd15, 3'd5);
        do_scan(3'd2, 3'd2, 1, 0, 0, 7'd0, 4'd0, 3'd2);
        do_scan(3'd0, 3'd7, 8, 3, 0, 7'd56, 4'd15, 3'd3);
        do_scan(3'd0, 3'd7, 8, 0, 4, 7'd56, 4'd15, 3'd3);
        do_scan(3'd0, 3'd7, 8, 0, 0, 7'd56, 4'd15, 3'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
